vga_text_writer: RTL and testbench

//  Upstream feeder of the character RAM (port A). Takes an ASCII byte stream (valid/ready) from the

---
 rtl/vga_text_writer_pkg.sv | 25 ++
 rtl/vga_cursor_ctr.sv | 103 ++++++++++
 rtl/vga_text_writer.sv | 105 ++++++++++
 tb/tb_vga_text_writer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_text_writer_pkg.sv
// Shared constants for the character-RAM text writer: screen geometry, ASCII codes, FSM states.
package vga_text_writer_pkg;

    localparam int unsigned N_COLS     = 80;
    localparam int unsigned N_ROWS     = 30;
    localparam int unsigned BIT_WIDTH  = 7;
    localparam int unsigned ADDR_WIDTH = 12;
    localparam int unsigned TAB_WIDTH  = 8;
    localparam int unsigned COL_WIDTH  = 7;
    localparam int unsigned ROW_WIDTH  = 5;

    localparam logic [6:0] CLEAR_CHAR  = 7'h20;
    localparam logic [6:0] ASCII_LF    = 7'h0A;
    localparam logic [6:0] ASCII_CR    = 7'h0D;
    localparam logic [6:0] ASCII_BS    = 7'h08;
    localparam logic [6:0] ASCII_TAB   = 7'h09;
    localparam logic [6:0] ASCII_SPACE = 7'h20;
    localparam logic [6:0] ASCII_TILDE = 7'h7E;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

endpackage

// File: rtl/vga_cursor_ctr.sv
// Cursor position tracker: column, row and the linear char-RAM address, with all wrap rules.
module vga_cursor_ctr
    import vga_text_writer_pkg::*;
#(
    parameter int unsigned n_cols     = N_COLS,
    parameter int unsigned n_rows     = N_ROWS,
    parameter int unsigned addr_width = ADDR_WIDTH,
    parameter int unsigned tab_width  = TAB_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc,
    input  logic                  newline,
    input  logic                  cr,
    input  logic                  bs,
    input  logic                  tab,
    input  logic                  home,
    output logic [6:0]            col,
    output logic [4:0]            row,
    output logic [addr_width-1:0] addr
);

    localparam logic [6:0] col_last = 7'(n_cols - 1);
    localparam logic [4:0] row_last = 5'(n_rows - 1);
    localparam logic [6:0] tab_mask = 7'(tab_width - 1);

    logic [addr_width-1:0] row_base;
    logic [addr_width-1:0] row_base_n;
    logic [addr_width-1:0] addr_n;
    logic [6:0]            col_n;
    logic [4:0]            row_n;
    logic [7:0]            tab_col;
    logic                  row_adv;

    // Address is tracked incrementally from row_base so no multiplier is needed.
    always_comb begin
        col_n      = col;
        row_n      = row;
        row_base_n = row_base;
        addr_n     = addr;
        row_adv    = 1'b0;
        tab_col    = {1'b0, col | tab_mask} + 8'd1;

        if (home) begin
            col_n      = '0;
            row_n      = '0;
            row_base_n = '0;
            addr_n     = '0;
        end else if (inc) begin
            if (col == col_last) begin
                row_adv = 1'b1;
            end else begin
                col_n  = col + 7'd1;
                addr_n = addr + addr_width'(1);
            end
        end else if (newline) begin
            row_adv = 1'b1;
        end else if (cr) begin
            col_n  = '0;
            addr_n = row_base;
        end else if (bs) begin
            if (col != 7'd0) begin
                col_n  = col - 7'd1;
                addr_n = addr - addr_width'(1);
            end
        end else if (tab) begin
            if (tab_col >= 8'(n_cols)) begin
                row_adv = 1'b1;
            end else begin
                col_n  = tab_col[6:0];
                addr_n = row_base + addr_width'(tab_col);
            end
        end

        // Bottom row wraps to the top; no scrolling.
        if (row_adv) begin
            col_n = '0;
            if (row == row_last) begin
                row_n      = '0;
                row_base_n = '0;
            end else begin
                row_n      = row + 5'd1;
                row_base_n = row_base + addr_width'(n_cols);
            end
            addr_n = row_base_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col      <= '0;
            row      <= '0;
            row_base <= '0;
            addr     <= '0;
        end else begin
            col      <= col_n;
            row      <= row_n;
            row_base <= row_base_n;
            addr     <= addr_n;
        end
    end

endmodule

// File: rtl/vga_text_writer.sv
// Turns a valid/ready ASCII byte stream into character-RAM writes at a tracked cursor.
module vga_text_writer
    import vga_text_writer_pkg::*;
#(
    parameter int unsigned          n_cols     = N_COLS,
    parameter int unsigned          n_rows     = N_ROWS,
    parameter int unsigned          bit_width  = BIT_WIDTH,
    parameter int unsigned          addr_width = ADDR_WIDTH,
    parameter logic [bit_width-1:0] clear_char = bit_width'(CLEAR_CHAR),
    parameter int unsigned          tab_width  = TAB_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            char_in,
    input  logic                  char_valid,
    output logic                  char_ready,
    input  logic                  clear_req,
    output logic [addr_width-1:0] addr_a,
    output logic                  wr_en_a,
    output logic [bit_width-1:0]  data_wr_a,
    output logic [6:0]            cursor_col,
    output logic [4:0]            cursor_row,
    output logic                  busy
);

    localparam logic [addr_width-1:0] clr_last = addr_width'(n_cols * n_rows - 1);

    state_t                state;
    logic [addr_width-1:0] clr_cnt;
    logic [addr_width-1:0] cur_addr;
    logic [6:0]            code;
    logic                  unused_bit7;
    logic                  in_idle;
    logic                  accept;
    logic                  is_print;
    logic                  home;

    assign code        = char_in[6:0];
    assign unused_bit7 = char_in[7];
    assign in_idle     = (state == ST_IDLE);
    assign char_ready  = in_idle & ~clear_req;
    assign accept      = char_ready & char_valid;
    assign is_print    = (code >= ASCII_SPACE) && (code <= ASCII_TILDE);
    assign home        = (in_idle & clear_req) | ((state == ST_CLEAR) && (clr_cnt == clr_last));

    vga_cursor_ctr #(
        .n_cols     (n_cols),
        .n_rows     (n_rows),
        .addr_width (addr_width),
        .tab_width  (tab_width)
    ) u_cursor (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (accept & is_print),
        .newline (accept & (code == ASCII_LF)),
        .cr      (accept & (code == ASCII_CR)),
        .bs      (accept & (code == ASCII_BS)),
        .tab     (accept & (code == ASCII_TAB)),
        .home    (home),
        .col     (cursor_col),
        .row     (cursor_row),
        .addr    (cur_addr)
    );

    // Write strobe is a one-cycle pulse; address and data hold between writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_CLEAR;
            clr_cnt   <= '0;
            busy      <= 1'b1;
            wr_en_a   <= 1'b0;
            addr_a    <= '0;
            data_wr_a <= '0;
        end else begin
            wr_en_a <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    wr_en_a   <= 1'b1;
                    addr_a    <= clr_cnt;
                    data_wr_a <= clear_char;
                    if (clr_cnt == clr_last) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + addr_width'(1);
                    end
                end
                ST_IDLE: begin
                    if (clear_req) begin
                        state   <= ST_CLEAR;
                        busy    <= 1'b1;
                        clr_cnt <= '0;
                    end else if (char_valid && is_print) begin
                        wr_en_a   <= 1'b1;
                        addr_a    <= cur_addr;
                        data_wr_a <= bit_width'(code);
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_text_writer.sv
// Self-checking bench for vga_text_writer: vector table, corner-case sequences and a screen model.
module tb_vga_text_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic        clear_req;
    logic [11:0] addr_a;
    logic        wr_en_a;
    logic [6:0]  data_wr_a;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int         m_col, m_row;
    logic [6:0] scr [2400];
    logic [6:0] shadow [2400];
    logic       e_wr;
    logic [11:0] e_addr;
    logic [6:0] e_data;

    // Last sampled DUT outputs
    logic        a_wr;
    logic [11:0] a_addr;
    logic [6:0]  a_data, a_col;
    logic [4:0]  a_row;

    typedef struct {
        logic [7:0]  ch;
        logic        wr;
        logic [11:0] addr;
        logic [6:0]  data;
        logic [6:0]  col;
        logic [4:0]  row;
    } vec_t;

    vec_t tbl [16];

    vga_text_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .clear_req  (clear_req),
        .addr_a     (addr_a),
        .wr_en_a    (wr_en_a),
        .data_wr_a  (data_wr_a),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Character RAM image as a negedge-writing RAM would see it.
    always @(negedge clk) begin
        if (wr_en_a === 1'b1) shadow[addr_a] <= data_wr_a;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2400; i++) scr[i] = 7'h20;
        m_col  = 0;
        m_row  = 0;
        e_addr = 12'd2399;
        e_data = 7'h20;
    endtask

    task automatic model_newline();
        m_col = 0;
        m_row = (m_row + 1) % 30;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int code;
        code = int'(b) % 128;
        e_wr = 1'b0;
        if (code >= 32 && code <= 126) begin
            e_wr   = 1'b1;
            e_addr = 12'(m_row * 80 + m_col);
            e_data = 7'(code);
            scr[m_row * 80 + m_col] = 7'(code);
            m_col++;
            if (m_col == 80) model_newline();
        end else if (code == 10) begin
            model_newline();
        end else if (code == 13) begin
            m_col = 0;
        end else if (code == 8) begin
            if (m_col > 0) m_col--;
        end else if (code == 9) begin
            m_col = (m_col / 8 + 1) * 8;
            if (m_col >= 80) model_newline();
        end
    endtask

    task automatic sample();
        a_wr   = wr_en_a;
        a_addr = addr_a;
        a_data = data_wr_a;
        a_col  = cursor_col;
        a_row  = cursor_row;
    endtask

    task automatic send(input logic [7:0] b);
        char_in    = b;
        char_valid = 1'b1;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        sample();
    endtask

    // Send one byte and compare every output against the model.
    task automatic step(input logic [7:0] b, input string name);
        send(b);
        model_byte(b);
        chk(name, {a_wr, a_addr, a_data, a_col, a_row},
            {e_wr, e_addr, e_data, 7'(m_col), 5'(m_row)});
    endtask

    task automatic wait_clear();
        int  n = 0;
        int  badw = 0;
        bit  done = 0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(posedge clk);
            #1;
            if (wr_en_a === 1'b1) begin
                if (addr_a !== 12'(n) || data_wr_a !== 7'h20) badw++;
                n++;
            end
            if (busy === 1'b0) done = 1;
        end
        chk("clear_done", 32'(done), 32'd1);
        chk("clear_writes", 32'(n), 32'd2400);
        chk("clear_bad_writes", 32'(badw), 32'd0);
        chk("post_clear_state", {char_ready, cursor_col, cursor_row}, {1'b1, 7'd0, 5'd0});
        model_clear();
    endtask

    initial begin
        tbl[0]  = '{8'h41, 1'b1, 12'd0,  7'h41, 7'd1, 5'd0};
        tbl[1]  = '{8'h42, 1'b1, 12'd1,  7'h42, 7'd2, 5'd0};
        tbl[2]  = '{8'h0D, 1'b0, 12'd1,  7'h42, 7'd0, 5'd0};
        tbl[3]  = '{8'h08, 1'b0, 12'd1,  7'h42, 7'd0, 5'd0};
        tbl[4]  = '{8'h78, 1'b1, 12'd0,  7'h78, 7'd1, 5'd0};
        tbl[5]  = '{8'h79, 1'b1, 12'd1,  7'h79, 7'd2, 5'd0};
        tbl[6]  = '{8'h7A, 1'b1, 12'd2,  7'h7A, 7'd3, 5'd0};
        tbl[7]  = '{8'h09, 1'b0, 12'd2,  7'h7A, 7'd8, 5'd0};
        tbl[8]  = '{8'hC3, 1'b1, 12'd8,  7'h43, 7'd9, 5'd0};
        tbl[9]  = '{8'h08, 1'b0, 12'd8,  7'h43, 7'd8, 5'd0};
        tbl[10] = '{8'h07, 1'b0, 12'd8,  7'h43, 7'd8, 5'd0};
        tbl[11] = '{8'h0A, 1'b0, 12'd8,  7'h43, 7'd0, 5'd1};
        tbl[12] = '{8'h7E, 1'b1, 12'd80, 7'h7E, 7'd1, 5'd1};
        tbl[13] = '{8'h7F, 1'b0, 12'd80, 7'h7E, 7'd1, 5'd1};
        tbl[14] = '{8'h1F, 1'b0, 12'd80, 7'h7E, 7'd1, 5'd1};
        tbl[15] = '{8'h20, 1'b1, 12'd81, 7'h20, 7'd2, 5'd1};

        rst_n      = 1'b0;
        clear_req  = 1'b0;
        char_valid = 1'b0;
        char_in    = 8'h00;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {busy, char_ready, wr_en_a, addr_a, data_wr_a, cursor_col, cursor_row},
            {1'b1, 1'b0, 1'b0, 12'd0, 7'd0, 7'd0, 5'd0});
        rst_n = 1'b1;
        wait_clear();

        // Vector table from home on a blank screen
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("tbl_ready_%0d", i), 32'(char_ready), 32'd1);
            send(tbl[i].ch);
            model_byte(tbl[i].ch);
            chk($sformatf("tbl_vec_%0d", i), {a_wr, a_addr, a_data, a_col, a_row},
                {tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].col, tbl[i].row});
        end

        // clear_req with a valid byte: byte refused, full clear follows
        clear_req  = 1'b1;
        char_valid = 1'b1;
        char_in    = 8'h51;
        #1;
        chk("clr_ready_low", 32'(char_ready), 32'd0);
        @(posedge clk);
        #1;
        clear_req  = 1'b0;
        char_valid = 1'b0;
        chk("clr_no_accept", {wr_en_a, busy}, {1'b0, 1'b1});
        wait_clear();

        // Row wrap on a full line
        for (int i = 0; i < 80; i++) step(8'h78, "fill_row");
        step(8'h79, "y_after_row");
        chk("y_at_80", {a_wr, a_addr, a_data, a_col, a_row}, {1'b1, 12'd80, 7'h79, 7'd1, 5'd1});

        // LF from the bottom row wraps to the top
        for (int i = 0; i < 28; i++) step(8'h0A, "lf_down");
        for (int i = 0; i < 5; i++) step(8'h6B, "row29_fill");
        chk("at_29_5", {a_col, a_row}, {7'd5, 5'd29});
        step(8'h0A, "lf_bottom");
        chk("lf_wrap", {a_wr, a_col, a_row}, {1'b0, 7'd0, 5'd0});
        step(8'h5A, "z_top");
        chk("z_at_0", {a_wr, a_addr, a_data}, {1'b1, 12'd0, 7'h5A});

        // TAB near the right edge wraps to the next row
        step(8'h0D, "cr");
        for (int i = 0; i < 77; i++) step(8'h6D, "to_col77");
        step(8'h09, "tab_77");
        chk("tab_wrap", {a_wr, a_col, a_row}, {1'b0, 7'd0, 5'd1});

        // Random traffic against the model, including idle cycles
        for (int i = 0; i < 600; i++) begin
            int sel;
            logic [7:0] b;
            sel = int'($urandom_range(0, 11));
            case (sel)
                0: b = 8'h0A;
                1: b = 8'h0D;
                2: b = 8'h08;
                3, 4: b = 8'h09;
                5: b = 8'($urandom);
                default: b = {1'($urandom), 7'(32 + $urandom_range(0, 94))};
            endcase
            if (sel == 6 && $urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
                chk("rand_idle", {wr_en_a, cursor_col, cursor_row}, {1'b0, 7'(m_col), 5'(m_row)});
            end else begin
                step(b, "rand_byte");
            end
        end
        @(posedge clk);
        #1;
        begin
            int nbad = 0;
            for (int i = 0; i < 2400; i++) if (shadow[i] !== scr[i]) nbad++;
            chk("screen_image", 32'(nbad), 32'd0);
        end

        // Reset during a clear restarts it from address 0
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        begin
            bit hit = 0;
            for (int k = 0; k < 3000 && !hit; k++) begin
                @(posedge clk);
                #1;
                if (wr_en_a === 1'b1 && addr_a == 12'd1000) hit = 1;
            end
            chk("reached_1000", 32'(hit), 32'd1);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_reset_state", {busy, wr_en_a, addr_a, data_wr_a}, {1'b1, 1'b0, 12'd0, 7'd0});
        rst_n = 1'b1;
        wait_clear();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
